// File: rtl/biometrics_pkg.sv
// Shared types for the biometrics capture path: session FSM states and the
// externally visible session mode encoding.
package biometrics_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENROLL,
        ST_DETECT,
        ST_WAIT_SCORE,
        ST_HOLD
    } session_state_t;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_IDLE   = 2'd0,
        MODE_ENROLL = 2'd1,
        MODE_DETECT = 2'd2
    } session_mode_t;

    function automatic logic is_capture(input session_state_t s);
        return (s == ST_ENROLL) || (s == ST_DETECT);
    endfunction

endpackage

// File: rtl/frame_gate.sv
// Whole-frame gate between the FFT stream and the feature extractor: frame
// alignment, handshake muxing, session frame counter and deferred abort.
module frame_gate
    import biometrics_pkg::*;
#(
    parameter int FRAMES = 32,
    parameter int CNT_W  = $clog2(FRAMES + 1)
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  session_state_t   state,
    input  logic             start,
    input  logic             abort_req,
    input  logic             fft_valid_in,
    input  logic             fft_last_in,
    input  logic             fe_ready_in,
    output logic             fft_ready_out,
    output logic             fe_valid_out,
    output logic             fe_last_out,
    output logic [CNT_W-1:0] frame_count,
    output logic             frame_done,
    output logic             abort_done
);

    localparam logic [CNT_W-1:0] FRAMES_C = CNT_W'(FRAMES);
    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(FRAMES - 1);

    logic cap;
    logic gate_open;
    logic accept;
    logic gated_acc;
    logic gated_last;
    logic aligned;
    logic in_frame;
    logic in_frame_nxt;
    logic gated_mid;
    logic mid_nxt;
    logic abort_pending;

    assign cap       = is_capture(state);
    assign gate_open = cap & aligned & (frame_count < FRAMES_C);

    // Closed gate keeps the FFT core flowing and drops its beats.
    assign fft_ready_out = gate_open ? fe_ready_in : 1'b1;
    assign fe_valid_out  = gate_open & fft_valid_in;
    assign fe_last_out   = gate_open & fft_last_in;

    assign accept       = fft_valid_in & fft_ready_out;
    assign gated_acc    = gate_open & accept;
    assign gated_last   = gated_acc & fft_last_in;
    assign in_frame_nxt = accept ? ~fft_last_in : in_frame;
    assign mid_nxt      = gated_acc ? ~fft_last_in : gated_mid;

    assign frame_done = gated_last & (frame_count == LAST_C);
    assign abort_done = cap & ((abort_req & ~mid_nxt) | (abort_pending & gated_last));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            in_frame      <= 1'b0;
            aligned       <= 1'b0;
            frame_count   <= '0;
            gated_mid     <= 1'b0;
            abort_pending <= 1'b0;
        end else begin
            in_frame <= in_frame_nxt;
            if (start) begin
                aligned       <= ~in_frame_nxt;
                frame_count   <= '0;
                gated_mid     <= 1'b0;
                abort_pending <= 1'b0;
            end else if (!cap) begin
                gated_mid     <= 1'b0;
                abort_pending <= 1'b0;
            end else begin
                if (accept && fft_last_in && !aligned)
                    aligned <= 1'b1;
                if (gated_last && frame_count < FRAMES_C)
                    frame_count <= frame_count + 1'b1;
                gated_mid <= mid_nxt;
                if (abort_req && mid_nxt)
                    abort_pending <= 1'b1;
                else if (gated_last)
                    abort_pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/voice_session_sequencer.sv
// Session sequencer for the biometrics pipeline: enroll/detect FSM, idle
// timeout, detection hold, with the frame gate as a sub-block.
//
// state         | meaning
// ST_IDLE       | no session, waiting for enroll/detect request
// ST_ENROLL     | forwarding frames, template write enabled
// ST_DETECT     | forwarding frames for classification
// ST_WAIT_SCORE | all frames sent, waiting for classifier verdict
// ST_HOLD       | match reported, detected_out held high
module voice_session_sequencer
    import biometrics_pkg::*;
#(
    parameter int FRAMES_PER_SESSION = 32,
    parameter int TIMEOUT_CYCLES     = 100_000_000,
    parameter int HOLD_CYCLES        = 50_000_000
) (
    input  logic                                   clk_in,
    input  logic                                   rst_n_in,
    input  logic                                   enroll_req_in,
    input  logic                                   detect_req_in,
    input  logic                                   abort_in,
    input  logic                                   fft_valid_in,
    input  logic                                   fft_last_in,
    output logic                                   fft_ready_out,
    output logic                                   fe_valid_out,
    output logic                                   fe_last_out,
    input  logic                                   fe_ready_in,
    input  logic                                   score_valid_in,
    input  logic                                   score_match_in,
    output logic                                   write_enable_out,
    output logic [MODE_W-1:0]                      mode_out,
    output logic [$clog2(FRAMES_PER_SESSION+1)-1:0] frame_count_out,
    output logic                                   busy_out,
    output logic                                   detected_out,
    output logic                                   timeout_out
);

    localparam int CNT_W  = $clog2(FRAMES_PER_SESSION + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    session_state_t    state, state_nxt;
    session_mode_t     mode;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              start;
    logic              accept;
    logic              timed_state;
    logic              tmo_hit;
    logic              hold_done;
    logic              frame_done;
    logic              abort_done;

    assign start       = (state == ST_IDLE) & (enroll_req_in | detect_req_in);
    assign accept      = fft_valid_in & fft_ready_out;
    assign timed_state = is_capture(state) | (state == ST_WAIT_SCORE);
    assign tmo_hit     = timed_state & ~accept & (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign hold_done   = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));

    frame_gate #(
        .FRAMES (FRAMES_PER_SESSION),
        .CNT_W  (CNT_W)
    ) u_frame_gate (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .state         (state),
        .start         (start),
        .abort_req     (abort_in),
        .fft_valid_in  (fft_valid_in),
        .fft_last_in   (fft_last_in),
        .fe_ready_in   (fe_ready_in),
        .fft_ready_out (fft_ready_out),
        .fe_valid_out  (fe_valid_out),
        .fe_last_out   (fe_last_out),
        .frame_count   (frame_count_out),
        .frame_done    (frame_done),
        .abort_done    (abort_done)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (enroll_req_in)      state_nxt = ST_ENROLL;
                else if (detect_req_in) state_nxt = ST_DETECT;
            end
            ST_ENROLL, ST_DETECT: begin
                if (abort_done || tmo_hit) state_nxt = ST_IDLE;
                else if (frame_done)       state_nxt = (state == ST_ENROLL) ? ST_IDLE : ST_WAIT_SCORE;
            end
            ST_WAIT_SCORE: begin
                if (abort_in || tmo_hit) state_nxt = ST_IDLE;
                else if (score_valid_in) state_nxt = score_match_in ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (abort_in || hold_done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_out         = 1'b1;
        write_enable_out = 1'b0;
        detected_out     = 1'b0;
        mode             = MODE_DETECT;
        case (state)
            ST_IDLE: begin
                busy_out = 1'b0;
                mode     = MODE_IDLE;
            end
            ST_ENROLL: begin
                write_enable_out = 1'b1;
                mode             = MODE_ENROLL;
            end
            ST_HOLD:  detected_out = 1'b1;
            default: ;
        endcase
    end

    assign mode_out = mode;

    // Both counters restart on every state change, so they never wrap.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tmo_cnt     <= '0;
            hold_cnt    <= '0;
            timeout_out <= 1'b0;
        end else begin
            timeout_out <= tmo_hit;
            if (state_nxt != state || accept)
                tmo_cnt <= '0;
            else if (timed_state)
                tmo_cnt <= tmo_cnt + 1'b1;
            if (state == ST_HOLD && state_nxt == ST_HOLD)
                hold_cnt <= hold_cnt + 1'b1;
            else
                hold_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_voice_session_sequencer.sv
// Directed bench for voice_session_sequencer; forwarded beats are checked
// against a queue of expected fe_last values pushed at drive time.
module tb_voice_session_sequencer;

    localparam int FRAMES = 2;
    localparam int TMO    = 16;
    localparam int HOLD   = 6;
    localparam int CNT_W  = $clog2(FRAMES + 1);

    logic             clk_in;
    logic             rst_n_in;
    logic             enroll_req_in, detect_req_in, abort_in;
    logic             fft_valid_in, fft_last_in, fft_ready_out;
    logic             fe_valid_out, fe_last_out, fe_ready_in;
    logic             score_valid_in, score_match_in;
    logic             write_enable_out;
    logic [1:0]       mode_out;
    logic [CNT_W-1:0] frame_count_out;
    logic             busy_out, detected_out, timeout_out;

    int   checks;
    int   errors;
    int   fwd_cnt;
    logic exp_q[$];

    voice_session_sequencer #(
        .FRAMES_PER_SESSION (FRAMES),
        .TIMEOUT_CYCLES     (TMO),
        .HOLD_CYCLES        (HOLD)
    ) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .enroll_req_in    (enroll_req_in),
        .detect_req_in    (detect_req_in),
        .abort_in         (abort_in),
        .fft_valid_in     (fft_valid_in),
        .fft_last_in      (fft_last_in),
        .fft_ready_out    (fft_ready_out),
        .fe_valid_out     (fe_valid_out),
        .fe_last_out      (fe_last_out),
        .fe_ready_in      (fe_ready_in),
        .score_valid_in   (score_valid_in),
        .score_match_in   (score_match_in),
        .write_enable_out (write_enable_out),
        .mode_out         (mode_out),
        .frame_count_out  (frame_count_out),
        .busy_out         (busy_out),
        .detected_out     (detected_out),
        .timeout_out      (timeout_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pops the scoreboard on a downstream transfer, then advances one clock.
    task automatic tick();
        logic exp_l;
        #1;
        if (rst_n_in && fe_valid_out && fe_ready_in) begin
            fwd_cnt++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_beat: observed fe_valid 1 expected no beat");
            end
            if (exp_q.size() != 0) begin
                exp_l = exp_q.pop_front();
                check("fe_last", fe_last_out, exp_l);
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic beat(input logic last, input logic fwd);
        fft_valid_in = 1'b1;
        fft_last_in  = last;
        if (fwd) exp_q.push_back(last);
    endtask

    task automatic idle_in();
        fft_valid_in = 1'b0;
        fft_last_in  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_det, n_busy, n_tmo, tmo_at, k, base;
        checks = 0; errors = 0; fwd_cnt = 0;
        rst_n_in = 1'b0;
        enroll_req_in = 0; detect_req_in = 0; abort_in = 0;
        fft_valid_in = 1; fft_last_in = 0; fe_ready_in = 1;
        score_valid_in = 0; score_match_in = 0;
        repeat (2) @(posedge clk_in);
        #2;
        check("rst_busy", busy_out, 0);
        check("rst_we", write_enable_out, 0);
        check("rst_det", detected_out, 0);
        check("rst_tmo", timeout_out, 0);
        check("rst_mode", mode_out, 0);
        check("rst_count", frame_count_out, 0);
        check("rst_fe_valid", fe_valid_out, 0);
        check("rst_fft_ready", fft_ready_out, 1);
        idle_in();
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
        tick();

        // Detect session requested mid-frame
        beat(0, 0); tick();
        detect_req_in = 1; beat(0, 0); tick(); detect_req_in = 0;
        check("det_busy", busy_out, 1);
        check("det_mode", mode_out, 2);
        check("det_we", write_enable_out, 0);
        beat(0, 0); #1;
        check("discard_valid", fe_valid_out, 0);
        check("discard_ready", fft_ready_out, 1);
        tick();
        beat(1, 0); tick();
        base = fwd_cnt;
        for (int f = 0; f < FRAMES; f++) begin
            for (int b = 0; b < 4; b++) begin
                beat(b == 3, 1); tick();
            end
            check("det_count", frame_count_out, f + 1);
        end
        check("det_beats", fwd_cnt - base, 8);
        check("wait_busy", busy_out, 1);
        check("wait_mode", mode_out, 2);
        beat(1, 0); #1;
        check("wait_closed", fe_valid_out, 0);
        check("wait_ready", fft_ready_out, 1);
        tick();
        idle_in();
        score_valid_in = 1; score_match_in = 1; tick();
        score_valid_in = 0; score_match_in = 0;
        n_det = 0;
        for (int i = 0; i < 20; i++) begin
            if (detected_out) n_det++;
            tick();
        end
        check("hold_len", n_det, HOLD);
        check("hold_busy_end", busy_out, 0);

        // Simultaneous requests, enroll with fe_ready toggling
        enroll_req_in = 1; detect_req_in = 1; tick();
        enroll_req_in = 0; detect_req_in = 0;
        check("both_mode", mode_out, 1);
        check("both_we", write_enable_out, 1);
        detect_req_in = 1; tick(); detect_req_in = 0;
        check("ign_mode", mode_out, 1);
        k = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            fe_ready_in = (c % 2 == 1);
            beat(k % 4 == 3, fe_ready_in);
            #1;
            check("ready_track", fft_ready_out, fe_ready_in);
            check("enr_we", write_enable_out, 1);
            if (fe_ready_in) k++;
            tick();
        end
        check("enr_beats", k, 8);
        fe_ready_in = 1; idle_in();
        check("enr_done_busy", busy_out, 0);
        check("enr_done_we", write_enable_out, 0);
        check("enr_done_mode", mode_out, 0);
        check("enr_count", frame_count_out, 2);

        // Abort on beat 2 of a gated frame
        detect_req_in = 1; tick(); detect_req_in = 0;
        beat(0, 1); tick();
        beat(0, 1); abort_in = 1; tick(); abort_in = 0;
        beat(0, 1); #1;
        check("abort_fwd", fe_valid_out, 1);
        tick();
        check("abort_busy_mid", busy_out, 1);
        beat(1, 1); #1;
        check("abort_last", fe_last_out, 1);
        tick();
        idle_in();
        check("abort_idle", busy_out, 0);
        check("abort_count", frame_count_out, 1);

        // Timeout with no upstream activity
        detect_req_in = 1; tick(); detect_req_in = 0;
        n_busy = 0; n_tmo = 0; tmo_at = -1;
        for (int i = 0; i < 40; i++) begin
            if (busy_out) n_busy++;
            if (timeout_out) begin
                n_tmo++;
                tmo_at = i;
            end
            tick();
        end
        check("tmo_busy_len", n_busy, TMO);
        check("tmo_pulses", n_tmo, 1);
        check("tmo_at", tmo_at, TMO);

        // Reset while waiting for a score
        detect_req_in = 1; tick(); detect_req_in = 0;
        for (int i = 0; i < 8; i++) begin
            beat(i % 4 == 3, 1); tick();
        end
        check("pre_rst_mode", mode_out, 2);
        check("pre_rst_count", frame_count_out, 2);
        beat(0, 0);
        #1 rst_n_in = 1'b0;
        #1;
        check("arst_busy", busy_out, 0);
        check("arst_mode", mode_out, 0);
        check("arst_count", frame_count_out, 0);
        check("arst_we", write_enable_out, 0);
        check("arst_det", detected_out, 0);
        check("arst_tmo", timeout_out, 0);
        check("arst_fe_valid", fe_valid_out, 0);
        check("arst_fft_ready", fft_ready_out, 1);
        idle_in();
        tick(); tick();
        rst_n_in = 1'b1;
        tick();
        score_valid_in = 1; score_match_in = 1; tick();
        score_valid_in = 0; score_match_in = 0;
        check("post_rst_busy", busy_out, 0);
        check("post_rst_det", detected_out, 0);
        tick();
        check("post_rst_det2", detected_out, 0);

        check("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/voice_session_sequencer.md
# voice_session_sequencer

Sequences capture sessions for the biometrics pipeline. It gates whole FFT frames from the FFT core into the feature extractor, and selects between enrollment (template write over BLE) and detection (wait for a classifier verdict). It also owns session frame counting, timeouts and the `detected_out` hold. It sits between the FFT output stream and `feature_extractor`, and drives the write-enable into the bluetooth/template path.

## Interface
Parameters:
- `FRAMES_PER_SESSION`, 32: whole FFT frames forwarded per session (≥1).
- `TIMEOUT_CYCLES`, 100_000_000: idle cycles tolerated in any capture/wait state.
- `HOLD_CYCLES`, 50_000_000: cycles `detected_out` stays high after a match.

Ports:
- `clk_in`  in  1  system clock; one clock, all logic on rising edge.
- `rst_n_in`  in  1  reset; asynchronous, active-low.
- `enroll_req_in`  in  1  single-cycle pulse; start an enrollment session.
- `detect_req_in`  in  1  single-cycle pulse; start a detection session.
- `abort_in`  in  1  single-cycle pulse; end the current session.
- `fft_valid_in`, `fft_last_in`  in  1 each  upstream FFT beat handshake (data bypasses this block).
- `fft_ready_out`  out  1  ready to the FFT core.
- `fe_valid_out`, `fe_last_out`  out  1 each  gated handshake to `feature_extractor`.
- `fe_ready_in`  in  1  `feature_extractor` ready.
- `score_valid_in`, `score_match_in`  in  1 each  classifier verdict strobe and result.
- `write_enable_out`  out  1  template write enable; high only in ENROLL.
- `mode_out`  out  2  0 idle, 1 enroll, 2 detect.
- `frame_count_out`  out  $clog2(FRAMES_PER_SESSION+1)  frames forwarded this session.
- `busy_out`, `detected_out`, `timeout_out`  out  1 each.

## Operation
- States: IDLE, ENROLL, DETECT, WAIT_SCORE, HOLD.
- IDLE:
  - `enroll_req_in` goes to ENROLL; `detect_req_in` goes to DETECT.
  - If both requests arrive in the same cycle, enroll wins.
  - Requests in any other state are ignored.
- Entering ENROLL or DETECT clears `frame_count_out`, the timeout counter and the `aligned` flag.
- Frame alignment:
  - `aligned` is set on the first accepted upstream beat with `fft_last_in=1` after entry, or immediately if the upstream is between frames (last beat seen previously, no partial frame in flight).
  - Until `aligned` is set, the gate is closed.
- Gate:
  - `gate_open` = capture state & `aligned` & count < `FRAMES_PER_SESSION`.
  - Open: `fe_valid_out`=`fft_valid_in`, `fe_last_out`=`fft_last_in`, `fft_ready_out`=`fe_ready_in`.
  - Closed: `fe_valid_out`=0 and `fft_ready_out`=1, so the FFT core never stalls and ungated beats are discarded.
- Each gated beat with valid&ready&last increments `frame_count_out` (saturates at `FRAMES_PER_SESSION`).
- When the count reaches `FRAMES_PER_SESSION`:
  - ENROLL goes to IDLE.
  - DETECT goes to WAIT_SCORE.
- WAIT_SCORE:
  - `score_valid_in` with `score_match_in=1` goes to HOLD.
  - `score_valid_in` with `score_match_in=0` goes to IDLE.
  - `score_valid_in` in any other state is ignored.
- HOLD: `detected_out`=1 for exactly `HOLD_CYCLES` cycles, then IDLE. Requests are ignored during HOLD.
- Abort:
  - If a gated frame is partially forwarded, set `abort_pending`; the gate stays open until that frame's last beat, then the state goes to IDLE.
  - Otherwise go to IDLE next cycle.
  - Abort in WAIT_SCORE or HOLD goes to IDLE immediately.
- Timeout:
  - The counter clears on any accepted upstream beat and on state entry.
  - Reaching `TIMEOUT_CYCLES` in ENROLL, DETECT or WAIT_SCORE pulses `timeout_out` for one cycle and goes to IDLE.
  - A partial gated frame is abandoned (downstream resets its own frame state).
- `busy_out` = state ≠ IDLE.
- `write_enable_out` = state==ENROLL.

## Timing
- Reset (async assert, sync release) values:
  - state IDLE.
  - `write_enable_out`, `busy_out`, `detected_out`, `timeout_out` = 0.
  - `mode_out`=0, `frame_count_out`=0.
  - `fe_valid_out`=0, `fft_ready_out`=1.
- Handshake path is combinational through the registered `gate_open`: zero-cycle latency, no buffering.
- The gate opens the cycle after the aligning last beat and closes the cycle after the Nth counted last beat.
- State, mode and `write_enable_out` change one cycle after the causing event.
- Reset mid-session truncates the downstream frame; this is acceptable.
- Counters are sized by `$clog2` of their limits and never wrap.

## Structure
- `biometrics_pkg`: `session_state_t` enum, `session_mode_t` (MODE_IDLE/ENROLL/DETECT), mode width constant.
- One sub-module, `frame_gate`: alignment flag, gate muxing, frame counter and `abort_pending`.
- The FSM, timeout and hold counters stay in the top level.

## Test plan
- Detect, FRAMES=2, upstream 4-beat frames, request mid-frame:
  - First partial frame is discarded with `fft_ready_out`=1.
  - Exactly 8 beats reach `fe_*`; `frame_count_out`=2.
  - `score_valid_in`=1 with match=1 gives `detected_out` high for exactly HOLD_CYCLES, then `busy_out`=0.
- Enroll with `fe_ready_in` toggling:
  - `fft_ready_out` tracks `fe_ready_in` while open.
  - `write_enable_out` is high only in ENROLL; IDLE after 2 frames.
- Simultaneous `enroll_req_in` and `detect_req_in` in IDLE gives `mode_out`=1; `detect_req_in` during ENROLL is ignored.
- Abort on beat 2 of a gated frame: beats 3–4 are still forwarded with `fe_last_out`, then IDLE; `frame_count_out`=1.
- TIMEOUT_CYCLES=16, no upstream beats in DETECT: `timeout_out` pulses for one cycle at cycle 16, then IDLE.
- Assert `rst_n_in` in WAIT_SCORE: all outputs take reset values asynchronously; a later `score_valid_in` is ignored.
